csr_trap_ctrl: RTL



---
 rtl/csr_trap_ctrl_pkg.sv | 30 +++
 rtl/csr_trap_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode trap controller:
//   - CSR addresses used by the trap/MRET write sequences
//   - mstatus bit positions (MIE, MPIE)
//   - controller state encoding
//   - default mcause value written for an external interrupt
// ----------------------------------------------------------------------------
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] IRQ_CAUSE_DEFAULT = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
    S_MSTATUS = 3'd3,
    S_MRET    = 3'd4,
    S_REDIR   = 3'd5
  } state_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// ----------------------------------------------------------------------------
// csr_trap_ctrl
// Sequences machine-mode trap entry, interrupt entry and MRET over the single
// shared CSR write port, arbitrating that port against instruction-issued CSR
// writes, and produces the fetch redirect.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   trap_req_i/trap_cause_i synchronous exception pulse + cause from commit
//   pc_i                    PC of faulting/interrupted instruction
//   mret_req_i              MRET commit pulse
//   irq_i                   external interrupt pending (level)
//   csr_req_i/addr/set/clr  instruction CSR write request
//   csr_gnt_o               instruction write accepted this cycle
//   csr_en_o/addr/set/clr   shared CSR write port (next = (v & ~clr) | set)
//   csr_ack_i               OR of all CSR unit acks
//   mstatus_i/mtvec_i/mepc_i current CSR values
//   redirect_o/redirect_pc_o one-cycle fetch redirect and target
//   busy_o                  sequence in progress; pipeline stalls
// ----------------------------------------------------------------------------
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] IRQ_CAUSE  = IRQ_CAUSE_DEFAULT,
  parameter int          RESET_IDLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] pc_i,
  input  logic        mret_req_i,
  input  logic        irq_i,
  input  logic        csr_req_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_set_i,
  input  logic [31:0] csr_clear_i,
  output logic        csr_gnt_o,
  output logic        csr_en_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_set_o,
  output logic [31:0] csr_clear_o,
  input  logic        csr_ack_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o
);

  // The controller only ever resets into S_IDLE; RESET_IDLE exists for
  // interface compatibility and must be left at 1.
  if (RESET_IDLE != 1) begin : g_reset_idle_unsupported
  end

  state_e      state_q, state_d;
  logic [29:0] pc_q, pc_d;        // word-aligned PC, low bits always written as 0
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;      // MIE at event acceptance, becomes MPIE
  logic        mret_q, mret_d;    // selects redirect target in S_REDIR

  // Bits of the inputs that the write sequences never look at.
  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], mtvec_i[1:0], mstatus_i[31:8],
                         mstatus_i[6:4], mstatus_i[2:0]};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cause_d       = cause_q;
    mie_d         = mie_q;
    mret_d        = mret_q;
    csr_gnt_o     = 1'b0;
    csr_en_o      = 1'b0;
    csr_addr_o    = 12'h000;
    csr_set_o     = 32'h0;
    csr_clear_o   = 32'h0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    busy_o        = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        // Fixed priority; losers in the same cycle are simply dropped and the
        // instruction port sees neither enable nor grant.
        if (trap_req_i) begin
          pc_d    = pc_i[31:2];
          cause_d = trap_cause_i;
          mie_d   = mstatus_i[MSTATUS_MIE];
          mret_d  = 1'b0;
          state_d = S_MEPC;
        end else if (mret_req_i) begin
          mret_d  = 1'b1;
          state_d = S_MRET;
        end else if (irq_i && mstatus_i[MSTATUS_MIE]) begin
          pc_d    = pc_i[31:2];
          cause_d = IRQ_CAUSE;
          mie_d   = mstatus_i[MSTATUS_MIE];
          mret_d  = 1'b0;
          state_d = S_MEPC;
        end else begin
          csr_en_o    = csr_req_i;
          csr_addr_o  = csr_addr_i;
          csr_set_o   = csr_set_i;
          csr_clear_o = csr_clear_i;
          csr_gnt_o   = csr_req_i & csr_ack_i;
        end
      end

      S_MEPC: begin
        csr_en_o    = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_clear_o = 32'hFFFF_FFFF;
        csr_set_o   = {pc_q, 2'b00};
        if (csr_ack_i) state_d = S_MCAUSE;
      end

      S_MCAUSE: begin
        csr_en_o    = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_clear_o = 32'hFFFF_FFFF;
        csr_set_o   = cause_q;
        if (csr_ack_i) state_d = S_MSTATUS;
      end

      S_MSTATUS: begin
        // MIE <- 0, MPIE <- MIE captured at acceptance.
        csr_en_o                  = 1'b1;
        csr_addr_o                = CSR_MSTATUS;
        csr_clear_o[MSTATUS_MIE]  = 1'b1;
        csr_clear_o[MSTATUS_MPIE] = 1'b1;
        csr_set_o[MSTATUS_MPIE]   = mie_q;
        if (csr_ack_i) state_d = S_REDIR;
      end

      S_MRET: begin
        // MIE <- MPIE, MPIE <- 1. MPIE is only set, so it needs no clear.
        csr_en_o                 = 1'b1;
        csr_addr_o               = CSR_MSTATUS;
        csr_clear_o[MSTATUS_MIE] = 1'b1;
        csr_set_o[MSTATUS_MIE]   = mstatus_i[MSTATUS_MPIE];
        csr_set_o[MSTATUS_MPIE]  = 1'b1;
        if (csr_ack_i) state_d = S_REDIR;
      end

      S_REDIR: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mret_q ? mepc_i : {mtvec_i[31:2], 2'b00};
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Reset aborts at once: no CSR write or redirect leaks out during the
    // reset cycle even though state_q still holds the old sequence state.
    if (rst_i) begin
      csr_gnt_o     = 1'b0;
      csr_en_o      = 1'b0;
      csr_addr_o    = 12'h000;
      csr_set_o     = 32'h0;
      csr_clear_o   = 32'h0;
      redirect_o    = 1'b0;
      redirect_pc_o = 32'h0;
      busy_o        = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mie_q   <= 1'b0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mie_q   <= mie_d;
      mret_q  <= mret_d;
    end
  end

endmodule
